// File: rtl/fp16_mul_norm_if.sv
// Handshake and operand/result bundle between the FP16 multiplier front end,
// the normalize/round back end, and whatever consumes the product.
interface fp16_mul_norm_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [4:0]  exp_sum;
  logic        ovf_in;
  logic        unf_in;
  logic        zero_in;
  logic [21:0] mant_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf_out;
  logic        unf_out;

  modport master (
    output in_valid, sign_in, exp_sum, ovf_in, unf_in, zero_in, mant_prod, out_ready,
    input  in_ready, out_valid, result, ovf_out, unf_out
  );

  modport slave (
    input  in_valid, sign_in, exp_sum, ovf_in, unf_in, zero_in, mant_prod, out_ready,
    output in_ready, out_valid, result, ovf_out, unf_out
  );
endinterface

// File: rtl/fp16_mul_norm.sv
// Back end of an FP16 multiplier: normalizes the 22-bit significand product,
// rounds to nearest-even, applies zero/overflow/underflow exceptions.
module fp16_mul_norm (
  input  logic           clk,
  input  logic           nRST,
  fp16_mul_norm_if.slave bus
);

  logic        adv;

  logic [9:0]  nrm_frac;
  logic        nrm_guard;
  logic        nrm_sticky;

  logic        s1_valid;
  logic        s1_sign;
  logic [4:0]  s1_exp;
  logic        s1_ovf;
  logic        s1_unf;
  logic        s1_zero;
  logic [9:0]  s1_frac;
  logic        s1_guard;
  logic        s1_sticky;

  logic        round_up;
  logic [10:0] frac_rnd;
  logic [5:0]  exp_rnd;
  logic [15:0] res_nxt;
  logic        ovf_nxt;
  logic        unf_nxt;

  logic        out_valid_q;
  logic [15:0] result_q;
  logic        ovf_q;
  logic        unf_q;

  // Both stages move as one; a stalled output freezes S1 too, so at most two
  // bundles are ever in flight and an empty S1 is never collapsed.
  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf_out   = ovf_q;
  assign bus.unf_out   = unf_q;

  always_comb begin
    nrm_frac   = bus.mant_prod[19:10];
    nrm_guard  = bus.mant_prod[9];
    nrm_sticky = |bus.mant_prod[8:0];
    if (bus.mant_prod[21]) begin
      nrm_frac   = bus.mant_prod[20:11];
      nrm_guard  = bus.mant_prod[10];
      nrm_sticky = |bus.mant_prod[9:0];
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= 5'd0;
      s1_ovf    <= 1'b0;
      s1_unf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_frac   <= 10'd0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign   <= bus.sign_in;
        s1_exp    <= bus.exp_sum;
        s1_ovf    <= bus.ovf_in;
        s1_unf    <= bus.unf_in;
        s1_zero   <= bus.zero_in;
        s1_frac   <= nrm_frac;
        s1_guard  <= nrm_guard;
        s1_sticky <= nrm_sticky;
      end
    end
  end

  // A carry out of the rounded fraction leaves the fraction at zero and bumps
  // the exponent; the 6-bit exponent lets that bump reach the overflow check.
  always_comb begin
    round_up = s1_guard & (s1_sticky | s1_frac[0]);
    frac_rnd = {1'b0, s1_frac} + {10'd0, round_up};
    exp_rnd  = {1'b0, s1_exp} + {5'd0, frac_rnd[10]};
    res_nxt  = {s1_sign, exp_rnd[4:0], frac_rnd[9:0]};
    ovf_nxt  = 1'b0;
    unf_nxt  = 1'b0;
    if (s1_zero) begin
      res_nxt = {s1_sign, 15'h0000};
    end else if (s1_ovf || (exp_rnd >= 6'd31)) begin
      res_nxt = {s1_sign, 5'h1F, 10'h000};
      ovf_nxt = 1'b1;
    end else if (s1_unf || (s1_exp == 5'd0)) begin
      res_nxt = {s1_sign, 15'h0000};
      unf_nxt = 1'b1;
    end
  end

  // Output register; an empty slot carries all-zero result and flags.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      out_valid_q <= 1'b0;
      result_q    <= 16'h0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        result_q <= res_nxt;
        ovf_q    <= ovf_nxt;
        unf_q    <= unf_nxt;
      end else begin
        result_q <= 16'h0000;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fp16_mul_norm.md
FP16_MUL_NORM -- requirements
Module: fp16_mul_norm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for FP16 (1/5/10).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream operand bundle valid.
REQ-005 in_ready  output  1  block accepts a bundle this cycle when high.
REQ-006 sign_in  input  1  XOR of operand signs.
REQ-007 exp_sum  input  5  biased result exponent from the exponent adder, already carry-adjusted (mant_prod[21] used as carry).
REQ-008 ovf_in  input  1  exponent adder overflow flag.
REQ-009 unf_in  input  1  exponent adder underflow flag.
REQ-010 zero_in  input  1  either operand is zero.
REQ-011 mant_prod  input  22  unsigned product of two 11-bit significands (hidden bit included).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 result  output  16  FP16 product {sign, exp[4:0], frac[9:0]}.
REQ-015 ovf_out  output  1  result saturated to infinity.
REQ-016 unf_out  output  1  result flushed to zero.

Function
REQ-017 Pipeline SHALL be two register stages, S1 (normalize) and S2 (round/except/output); latency 2 cycles from accepted input to out_valid.
REQ-018 Advance enable adv = ~out_valid | out_ready; all stages shift together only when adv=1; in_ready = adv.
REQ-019 Input accepted on a cycle with in_valid & in_ready; S1 valid loads in_valid when adv, holds otherwise.
REQ-020 S1 normalize: if mant_prod[21]=1, frac_pre=mant_prod[20:11], guard=mant_prod[10], sticky=|mant_prod[9:0]; else frac_pre=mant_prod[19:10], guard=mant_prod[9], sticky=|mant_prod[8:0].
REQ-021 S2 rounding SHALL be round-to-nearest-even: round_up = guard & (sticky | frac_pre[0]).
REQ-022 frac_pre=10'h3FF with round_up SHALL yield frac=0 and exponent exp_sum+1 (6-bit intermediate).
REQ-023 Exception priority in S2: zero_in > overflow > underflow > normal.
REQ-024 zero_in: result={sign,15'h0}, ovf_out=0, unf_out=0.
REQ-025 Overflow (ovf_in=1, or post-round exponent >=31): result={sign,5'h1F,10'h0}, ovf_out=1.
REQ-026 Underflow (unf_in=1, or exp_sum=0 without overflow): result={sign,15'h0}, unf_out=1; no subnormal outputs ever produced.
REQ-027 result, ovf_out, unf_out SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-028 When out stalled, in_ready=0 even if S1 is empty (no bubble collapse); maximum in-flight bundles = 2.
REQ-029 out_valid & out_ready with in_valid SHALL both retire the output and accept new input in the same cycle (full throughput 1/cycle).
REQ-030 Flags SHALL be 0 whenever out_valid=0.

Reset
REQ-031 nRST low SHALL immediately clear S1 valid and out_valid; result, ovf_out, unf_out =0; in_ready=1 once out_valid is 0.
REQ-032 Reset mid-operation SHALL discard all in-flight bundles; none appear after release.
REQ-033 First acceptance possible on the first rising clk after nRST deasserts.

Verification
REQ-034 1.5x1.5: mant_prod=22'h240000, exp_sum=16, sign 0, out_ready=1 -> two cycles later result=16'h4080, flags 0.
REQ-035 1.0x1.0: mant_prod=22'h100000, exp_sum=15 -> result=16'h3C00; tie case mant_prod=22'h1FFE00, exp_sum=15 -> round carries, result=16'h4000.
REQ-036 Overflow: exp_sum=30, mant_prod=22'h1FFE00 -> result=16'h7C00, ovf_out=1; ovf_in=1, sign 1 -> 16'hFC00, ovf_out=1; zero_in=1 with ovf_in=1 -> 16'h0000, flags 0.
REQ-037 Underflow: unf_in=1, sign 1 -> result=16'h8000, unf_out=1; exp_sum=0 -> 16'h0000, unf_out=1.
REQ-038 Backpressure: out_ready=0, in_valid=1 for 4 cycles -> exactly 2 accepted, in_ready=0 from cycle 3; out_ready=1 -> results emerge in order, unchanged while stalled.
REQ-039 Reset: nRST low with 2 bundles in flight -> out_valid=0 asynchronously; after release no stale result appears.
